// File: rtl/sync_framer_ctrl.sv
// Frame-sync controller: hunts for PATTERN, verifies it recurs every FRAME_LEN bits, locks,
// then delivers indexed payload bits. Define FRAMER_STATS_EN to add sync/slip counters.
module sync_framer_ctrl #(
    parameter int             PAT_W     = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             FRAME_LEN = 8,
    parameter int             LOCK_CNT  = 2,
    parameter int             LOSS_CNT  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          x,
    input  logic                          x_valid,
    output logic                          locked,
    output logic                          frame_sync,
    output logic                          sync_lost,
    output logic                          payload_bit,
    output logic                          payload_valid,
    output logic [$clog2(FRAME_LEN)-1:0]  payload_idx
`ifdef FRAMER_STATS_EN
    ,
    output logic [15:0]                   sync_count,
    output logic [7:0]                    slip_count
`endif
);

    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int FILL_W = $clog2(PAT_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [CNT_W-1:0]  CHECK_POS = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  PAY_END   = CNT_W'(FRAME_LEN - PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(LOSS_CNT);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]        state;
    // Only the previous PAT_W-1 bits are stored; the current x completes the window.
    logic [PAT_W-2:0]  window;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GOOD_W-1:0] good;
    logic [MISS_W-1:0] miss;

    logic [PAT_W-1:0]  cand;
    logic              fill_done;
    logic              match;
    logic              check_bit;
    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss_inc;
    logic              fs_set;
    logic              sl_set;

    always_comb begin
        cand      = {window, x};
        fill_done = (fill == FILL_MAX);
        match     = fill_done && (cand == PATTERN);
        check_bit = (bit_cnt == CHECK_POS);
        good_inc  = good + 1'b1;
        miss_inc  = miss + 1'b1;
        fs_set    = x_valid && (
                        (state == ST_HUNT   && match && LOCK_CNT == 1) ||
                        (state == ST_VERIFY && check_bit && match && good_inc == GOOD_TGT) ||
                        (state == ST_LOCKED && check_bit && match));
        sl_set    = x_valid && state == ST_LOCKED && check_bit && !match && miss_inc == MISS_TGT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_HUNT;
            window        <= '0;
            fill          <= '0;
            bit_cnt       <= '0;
            good          <= '0;
            miss          <= '0;
            locked        <= 1'b0;
            frame_sync    <= 1'b0;
            sync_lost     <= 1'b0;
            payload_bit   <= 1'b0;
            payload_valid <= 1'b0;
            payload_idx   <= '0;
        end else begin
            frame_sync    <= 1'b0;
            sync_lost     <= 1'b0;
            payload_valid <= 1'b0;
            if (x_valid) begin
                window  <= cand[PAT_W-2:0];
                if (!fill_done)
                    fill <= fill + 1'b1;
                bit_cnt <= check_bit ? '0 : bit_cnt + 1'b1;
                case (state)
                    ST_HUNT: begin
                        if (match) begin
                            bit_cnt <= '0;
                            good    <= GOOD_W'(1);
                            if (LOCK_CNT == 1) begin
                                state      <= ST_LOCKED;
                                locked     <= 1'b1;
                                frame_sync <= 1'b1;
                                miss       <= '0;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (check_bit) begin
                            if (!match) begin
                                state <= ST_HUNT;
                                good  <= '0;
                            end else if (good_inc == GOOD_TGT) begin
                                state      <= ST_LOCKED;
                                locked     <= 1'b1;
                                frame_sync <= 1'b1;
                                miss       <= '0;
                            end else begin
                                good <= good_inc;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (bit_cnt < PAY_END) begin
                            payload_valid <= 1'b1;
                            payload_bit   <= x;
                            payload_idx   <= bit_cnt;
                        end
                        // A bad sync is tolerated until LOSS_CNT of them arrive back to back.
                        if (check_bit) begin
                            if (match) begin
                                miss       <= '0;
                                frame_sync <= 1'b1;
                            end else if (miss_inc == MISS_TGT) begin
                                state     <= ST_HUNT;
                                locked    <= 1'b0;
                                sync_lost <= 1'b1;
                                miss      <= '0;
                                good      <= '0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

`ifdef FRAMER_STATS_EN
    // Saturating event counters, updated in the same cycle as the pulses they count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_count <= '0;
            slip_count <= '0;
        end else begin
            if (fs_set && sync_count != 16'hFFFF)
                sync_count <= sync_count + 1'b1;
            if (sl_set && slip_count != 8'hFF)
                slip_count <= slip_count + 1'b1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = fs_set ^ sl_set;
`endif

endmodule

// File: tb/tb_sync_framer_ctrl.sv
// Scoreboard bench for sync_framer_ctrl: stimulus pushes hand-computed events,
// a monitor pops and compares whenever the DUT pulses an output.
module tb_sync_framer_ctrl;

    localparam int EV_PAY  = 1;
    localparam int EV_SYNC = 2;
    localparam int EV_LOST = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b1;
    logic       locked;
    logic       frame_sync;
    logic       sync_lost;
    logic       payload_bit;
    logic       payload_valid;
    logic [2:0] payload_idx;
`ifdef FRAMER_STATS_EN
    logic [15:0] sync_count;
    logic [7:0]  slip_count;
`endif

    typedef struct {
        int   kind;
        logic pbit;
        int   pidx;
        logic lck;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;

    sync_framer_ctrl dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .x_valid(x_valid),
        .locked(locked),
        .frame_sync(frame_sync),
        .sync_lost(sync_lost),
        .payload_bit(payload_bit),
        .payload_valid(payload_valid),
        .payload_idx(payload_idx)
`ifdef FRAMER_STATS_EN
        ,
        .sync_count(sync_count),
        .slip_count(slip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one valid bit; a nonzero kind queues the response expected one cycle later.
    task automatic applyStimulus(input logic b, input int kind, input logic pb, input int pidx, input logic lck);
        ev_t e;
        @(negedge clk);
        x = b;
        x_valid = 1'b1;
        if (kind != 0) begin
            e.kind = kind;
            e.pbit = pb;
            e.pidx = pidx;
            e.lck  = lck;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        x_valid = 1'b0;
        x = 1'($urandom);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        x_valid = 1'b1;
        x = ~x;
        @(negedge clk);
        reset = 1'b0;
        x_valid = 1'b0;
    endtask

    // Frame is sent MSB first; the sync check lands on bit 3, payload on bits 4..7.
    task automatic sendFrame(input logic [7:0] f, input int sync_kind, input logic pay, input logic gaps);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = f[7-i];
            if (i == 3 && sync_kind != 0)
                applyStimulus(b, sync_kind, 1'b0, 0, sync_kind == EV_SYNC);
            else if (i >= 4 && pay)
                applyStimulus(b, EV_PAY, b, i - 4, 1'b1);
            else
                applyStimulus(b, 0, 1'b0, 0, 1'b0);
            if (gaps && (i == 1 || i == 5)) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++)
                    idle();
            end
        end
    endtask

    initial begin
        int act;
        ev_t e;
        forever begin
            @(negedge clk);
            if (frame_sync || sync_lost || payload_valid) begin
                act = (int'(payload_valid) + int'(frame_sync) + int'(sync_lost) > 1) ? 9 :
                      payload_valid ? EV_PAY : frame_sync ? EV_SYNC : EV_LOST;
                if (q.size() == 0) begin
                    checkOutput("unexpected_event", act, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("event_kind", act, e.kind);
                    checkOutput("event_locked", int'(locked), int'(e.lck));
                    if (e.kind == EV_PAY) begin
                        checkOutput("payload_bit", int'(payload_bit), int'(e.pbit));
                        checkOutput("payload_idx", int'(payload_idx), e.pidx);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with x toggling: every output stays low.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("rst_locked", int'(locked), 0);
            checkOutput("rst_frame_sync", int'(frame_sync), 0);
            checkOutput("rst_sync_lost", int'(sync_lost), 0);
            checkOutput("rst_payload_valid", int'(payload_valid), 0);
            x = ~x;
        end
        reset = 1'b0;
        x_valid = 1'b0;

        // Clean stream: verify at bit 4, lock at bit 12, payload 0110 each frame.
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        idle();
        checkOutput("t2_locked", int'(locked), 1);

        // Verification fails on the second sync: no lock.
        doReset();
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b0);
        sendFrame(8'b1001_0110, 0, 1'b0, 1'b0);
        sendFrame(8'b0000_0000, 0, 1'b0, 1'b0);
        idle();
        checkOutput("t3_locked", int'(locked), 0);

        // Flywheel over one bad sync, drop after two in a row.
        doReset();
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        sendFrame(8'b0011_0110, 0, 1'b1, 1'b0);
        idle();
        checkOutput("t4_flywheel_locked", int'(locked), 1);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        sendFrame(8'b0011_0110, 0, 1'b1, 1'b0);
        sendFrame(8'b0011_0110, EV_LOST, 1'b0, 1'b0);
        idle();
        checkOutput("t4_locked_after_loss", int'(locked), 0);
`ifdef FRAMER_STATS_EN
        checkOutput("t4_slip_count", int'(slip_count), 1);
`endif

        // Same as the clean stream but with x_valid gaps mid-frame.
        doReset();
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b1);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b1);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b1);
        idle();
        checkOutput("t5_locked", int'(locked), 1);

        // Reset at payload idx 2 while locked, then relock needs two syncs.
        doReset();
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, EV_SYNC, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, EV_PAY, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, EV_PAY, 1'b1, 1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        x_valid = 1'b1;
        x = 1'b1;
        @(negedge clk);
        checkOutput("t6_locked", int'(locked), 0);
        checkOutput("t6_frame_sync", int'(frame_sync), 0);
        checkOutput("t6_sync_lost", int'(sync_lost), 0);
        checkOutput("t6_payload_valid", int'(payload_valid), 0);
        checkOutput("t6_payload_bit", int'(payload_bit), 0);
        checkOutput("t6_payload_idx", int'(payload_idx), 0);
        reset = 1'b0;
        x_valid = 1'b0;
        sendFrame(8'b1011_0110, 0, 1'b0, 1'b0);
        idle();
        checkOutput("t6_not_relocked", int'(locked), 0);
        sendFrame(8'b1011_0110, EV_SYNC, 1'b1, 1'b0);
        idle();
        checkOutput("t6_relocked", int'(locked), 1);

        repeat (3) idle();
        checkOutput("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
